eth_tx_sched: RTL

ETH_TX_SCHED -- requirements
Module: eth_tx_sched

---
 rtl/eth_pkg.sv | 22 ++
 rtl/eth_ms_timer.sv | 31 +++
 rtl/eth_tx_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared codes for the Ethernet TX scheduler: packet types, ARP opcodes, FSM states.
// Pure declarations; no logic, no latency, no flow control.
package eth_pkg;

   typedef enum logic [3:0] {
      PKT_NONE     = 4'd0,
      PKT_ARP_REQ  = 4'd1,
      PKT_ARP_RESP = 4'd2,
      PKT_UDP      = 4'd3
   } pkt_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_BUSY
   } state_t;

   localparam logic [1:0]  ARP_OP_REQ   = 2'd1;
   localparam logic [1:0]  ARP_OP_REPLY = 2'd2;
   localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_ms_timer.sv
// Free-running 0..MS_DIV-1 divider producing a one-cycle millisecond strobe.
// Strobe is combinational from the counter; no backpressure, never stalls.
module eth_ms_timer #(
   parameter int MS_DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   output logic o_ms_tick
);

   localparam int            CW   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(MS_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_ms_tick = (cnt_q == LAST);

endmodule

// File: rtl/eth_tx_sched.sv
// Picks the next packet (ARP_RESP > ARP_REQ > UDP) and its destination; tracks the peer ARP cache.
// Grant registers one cycle after a pending flag; the sender paces the FSM with sop/eop strobes.
module eth_tx_sched
   import eth_pkg::*;
#(
   parameter int          MS_DIV         = 100000,
   parameter int          ARP_PERIOD_MS  = 3000,
   parameter int          ARP_TIMEOUT_MS = 3000,
   parameter logic [31:0] TARGET_IP      = 32'h0A00006F
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  i_arp_op,
   input  logic [47:0] i_arp_mac,
   input  logic [31:0] i_arp_ip,
   input  logic        i_udp_pend,
   input  logic        i_tx_sop,
   input  logic        i_tx_eop,
   output logic [3:0]  o_pkt_type,
   output logic [47:0] o_target_mac,
   output logic [31:0] o_target_ip,
   output logic        o_arp_valid
);

   localparam int            PW       = $clog2(ARP_PERIOD_MS + 1);
   localparam int            TW       = $clog2(ARP_TIMEOUT_MS + 1);
   localparam logic [PW-1:0] PER_LAST = PW'(ARP_PERIOD_MS - 1);
   localparam logic [PW-1:0] PER_MAX  = PW'(ARP_PERIOD_MS);
   localparam logic [TW-1:0] TO_LAST  = TW'(ARP_TIMEOUT_MS - 1);

   logic          ms_tick;
   state_t        state_q, state_d;
   pkt_t          sel_q, sel_d;
   logic [47:0]   mac_q, mac_d;
   logic [31:0]   ip_q, ip_d;
   logic          arp_valid_q, arp_valid_d;
   logic [47:0]   cache_mac_q, cache_mac_d;
   logic [47:0]   resp_mac_q, resp_mac_d;
   logic [31:0]   resp_ip_q, resp_ip_d;
   logic          req_pend_q, req_pend_d;
   logic          resp_pend_q, resp_pend_d;
   logic [PW-1:0] per_cnt_q, per_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          to_run_q, to_run_d;

   logic arp_req_evt, arp_rep_evt;
   logic udp_drop, sop_ok, req_sop, resp_sop;
   logic per_hit, to_hit;

   eth_ms_timer #(.MS_DIV(MS_DIV)) u_ms_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .o_ms_tick (ms_tick)
   );

   always_comb begin
      arp_req_evt = (i_arp_op == ARP_OP_REQ);
      arp_rep_evt = (i_arp_op == ARP_OP_REPLY);
      // A UDP grant is only meaningful while the peer MAC is known.
      udp_drop    = (state_q == ST_ARM) && (sel_q == PKT_UDP) && !arp_valid_q;
      sop_ok      = (state_q == ST_ARM) && i_tx_sop && !udp_drop;
      req_sop     = sop_ok && (sel_q == PKT_ARP_REQ);
      resp_sop    = sop_ok && (sel_q == PKT_ARP_RESP);

      per_hit   = ms_tick && (per_cnt_q == PER_LAST);
      per_cnt_d = per_cnt_q;
      if (req_sop) begin
         per_cnt_d = '0;
      end else if (ms_tick && (per_cnt_q != PER_MAX)) begin
         per_cnt_d = per_cnt_q + PW'(1);
      end

      to_hit   = to_run_q && ms_tick && (to_cnt_q == TO_LAST);
      to_run_d = to_run_q;
      to_cnt_d = to_cnt_q;
      if (req_sop) begin
         to_run_d = 1'b1;
         to_cnt_d = '0;
      end else if (arp_rep_evt || to_hit) begin
         to_run_d = 1'b0;
         to_cnt_d = '0;
      end else if (to_run_q && ms_tick) begin
         to_cnt_d = to_cnt_q + TW'(1);
      end

      // Reply beats a simultaneous timeout expiry.
      arp_valid_d = arp_valid_q;
      if (arp_rep_evt) begin
         arp_valid_d = 1'b1;
      end else if (to_hit) begin
         arp_valid_d = 1'b0;
      end
      cache_mac_d = arp_rep_evt ? i_arp_mac : cache_mac_q;

      resp_mac_d  = arp_req_evt ? i_arp_mac : resp_mac_q;
      resp_ip_d   = arp_req_evt ? i_arp_ip : resp_ip_q;
      resp_pend_d = arp_req_evt || (resp_pend_q && !resp_sop);
      req_pend_d  = per_hit || (req_pend_q && !req_sop);

      state_d = state_q;
      sel_d   = sel_q;
      mac_d   = mac_q;
      ip_d    = ip_q;
      case (state_q)
         ST_IDLE: begin
            if (resp_pend_q) begin
               state_d = ST_ARM;
               sel_d   = PKT_ARP_RESP;
               mac_d   = resp_mac_q;
               ip_d    = resp_ip_q;
            end else if (req_pend_q) begin
               state_d = ST_ARM;
               sel_d   = PKT_ARP_REQ;
               mac_d   = arp_valid_q ? cache_mac_q : BCAST_MAC;
               ip_d    = TARGET_IP;
            end else if (i_udp_pend && arp_valid_q) begin
               state_d = ST_ARM;
               sel_d   = PKT_UDP;
               mac_d   = cache_mac_q;
               ip_d    = TARGET_IP;
            end
         end
         ST_ARM: begin
            if (udp_drop || (i_tx_sop && i_tx_eop)) begin
               state_d = ST_IDLE;
               sel_d   = PKT_NONE;
            end else if (i_tx_sop) begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (i_tx_eop) begin
               state_d = ST_IDLE;
               sel_d   = PKT_NONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = PKT_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sel_q       <= PKT_NONE;
         mac_q       <= BCAST_MAC;
         ip_q        <= '0;
         arp_valid_q <= 1'b0;
         cache_mac_q <= '0;
         resp_mac_q  <= '0;
         resp_ip_q   <= '0;
         req_pend_q  <= 1'b1;
         resp_pend_q <= 1'b0;
         per_cnt_q   <= '0;
         to_cnt_q    <= '0;
         to_run_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         mac_q       <= mac_d;
         ip_q        <= ip_d;
         arp_valid_q <= arp_valid_d;
         cache_mac_q <= cache_mac_d;
         resp_mac_q  <= resp_mac_d;
         resp_ip_q   <= resp_ip_d;
         req_pend_q  <= req_pend_d;
         resp_pend_q <= resp_pend_d;
         per_cnt_q   <= per_cnt_d;
         to_cnt_q    <= to_cnt_d;
         to_run_q    <= to_run_d;
      end
   end

   assign o_pkt_type   = sel_q;
   assign o_target_mac = mac_q;
   assign o_target_ip  = ip_q;
   assign o_arp_valid  = arp_valid_q;

endmodule
